// File: rtl/pc_unit.sv
// Program-counter unit: sequential fetch, prioritised redirects, exception
// entry/return with misalignment trapping, and a low-power halt state.
module pc_unit #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'('h80),
    parameter int unsigned      STEP         = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             branch,
    input  logic             zero,
    input  logic [WIDTH-1:0] branchaddr,
    input  logic             jump,
    input  logic [WIDTH-1:0] jumpaddr,
    input  logic             jr,
    input  logic [WIDTH-1:0] jraddr,
    input  logic             exc,
    input  logic             eret,
    input  logic             halt,
    input  logic             irq,
    output logic [WIDTH-1:0] pcvalue,
    output logic [WIDTH-1:0] pcnext_seq,
    output logic [WIDTH-1:0] epc,
    output logic             misalign,
    output logic             halted
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             mis_q, mis_d;

    logic             redirect;
    logic [WIDTH-1:0] target;
    logic             target_misaligned;

    // Highest-priority register/immediate target among jr > jump > branch
    always_comb begin
        redirect = jr | jump | (branch & zero);
        if (jr) begin
            target = jraddr;
        end else if (jump) begin
            target = jumpaddr;
        end else begin
            target = branchaddr;
        end
        target_misaligned = redirect && (target[1:0] != 2'b00);
    end

    assign pcnext_seq = pc_q + STEP_W;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        mis_d   = 1'b0;
        case (state_q)
            ST_RUN: begin
                // exc and misaligned traps bypass stall; everything else honours it
                if (exc) begin
                    pc_d  = EXC_VECTOR;
                    epc_d = pc_q;
                end else if (eret) begin
                    if (!stall) begin
                        pc_d = epc_q;
                    end
                end else if (redirect) begin
                    if (target_misaligned) begin
                        pc_d  = EXC_VECTOR;
                        epc_d = pc_q;
                        mis_d = 1'b1;
                    end else if (!stall) begin
                        pc_d = target;
                    end
                end else if (!stall) begin
                    if (halt) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pcnext_seq;
                    end
                end
            end
            ST_HALT: begin
                if (irq || exc) begin
                    state_d = ST_RUN;
                    pc_d    = EXC_VECTOR;
                    epc_d   = pcnext_seq;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign pcvalue  = pc_q;
    assign epc      = epc_q;
    assign misalign = mis_q;
    assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios, then random stimulus
// against a behavioural model; a second 8-bit instance checks wrap-around.
module tb_pc_unit;

    localparam longint MOD32 = 64'h1_0000_0000;
    localparam longint EXCV  = 64'h80;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall, branch, zero, jump, jr, exc, eret, halt, irq;
    logic [31:0] branchaddr, jumpaddr, jraddr;
    logic [31:0] pcvalue, pcnext_seq, epc;
    logic        misalign, halted;

    logic [7:0]  z8 = 8'h00;
    logic [7:0]  pc8, pcn8, epc8;
    logic        mis8, halted8;

    int checks = 0;
    int errors = 0;

    longint m_pc, m_epc, m8;
    bit     m_halt, m_mis;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .branch(branch), .zero(zero),
        .branchaddr(branchaddr), .jump(jump), .jumpaddr(jumpaddr), .jr(jr),
        .jraddr(jraddr), .exc(exc), .eret(eret), .halt(halt), .irq(irq),
        .pcvalue(pcvalue), .pcnext_seq(pcnext_seq), .epc(epc),
        .misalign(misalign), .halted(halted)
    );

    pc_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .stall(1'b0), .branch(1'b0), .zero(1'b0),
        .branchaddr(z8), .jump(1'b0), .jumpaddr(z8), .jr(1'b0), .jraddr(z8),
        .exc(1'b0), .eret(1'b0), .halt(1'b0), .irq(1'b0),
        .pcvalue(pc8), .pcnext_seq(pcn8), .epc(epc8),
        .misalign(mis8), .halted(halted8)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        stall = 0; branch = 0; zero = 0; jump = 0; jr = 0;
        exc = 0; eret = 0; halt = 0; irq = 0;
        branchaddr = 0; jumpaddr = 0; jraddr = 0;
    endtask

    task automatic model_reset();
        m_pc = 0; m_epc = 0; m_halt = 0; m_mis = 0; m8 = 0;
    endtask

    // Behavioural next-state from the architectural rules
    task automatic model_step();
        longint tgt;
        m_mis = 0;
        if (m_halt) begin
            if (irq || exc) begin
                m_epc  = (m_pc + 4) % MOD32;
                m_pc   = EXCV;
                m_halt = 0;
            end
        end else if (exc) begin
            m_epc = m_pc;
            m_pc  = EXCV;
        end else if (eret) begin
            if (!stall) m_pc = m_epc;
        end else if (jr || jump || (branch && zero)) begin
            tgt = jr ? longint'(jraddr) : jump ? longint'(jumpaddr) : longint'(branchaddr);
            if (tgt % 4 != 0) begin
                m_epc = m_pc;
                m_pc  = EXCV;
                m_mis = 1;
            end else if (!stall) begin
                m_pc = tgt;
            end
        end else if (!stall) begin
            if (halt) m_halt = 1;
            else      m_pc = (m_pc + 4) % MOD32;
        end
        m8 = (m8 + 4) % 256;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},     longint'(pcvalue), m_pc);
        chk({tag, ".epc"},    longint'(epc), m_epc);
        chk({tag, ".mis"},    longint'(misalign), longint'(m_mis));
        chk({tag, ".halted"}, longint'(halted), longint'(m_halt));
        chk({tag, ".pcn"},    longint'(pcnext_seq), (m_pc + 4) % MOD32);
        chk({tag, ".pc8"},    longint'(pc8), m8);
        chk({tag, ".mis8"},   longint'(mis8), 0);
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
        idle();
    endtask

    task automatic async_reset(input string tag);
        reset_n = 0;
        #2;
        model_reset();
        check_all(tag);
        reset_n = 1;
    endtask

    task automatic go_to(input logic [31:0] a);
        jump = 1; jumpaddr = a;
        tick("goto");
    endtask

    initial begin
        idle();
        model_reset();
        #2;
        check_all("reset");
        @(posedge clk); #1;
        reset_n = 1;

        tick("seq4"); tick("seq8"); tick("seq12");
        chk("seq12.explicit", longint'(pcvalue), 12);
        async_reset("async_rst");

        go_to(32'h40);
        jump = 1; jumpaddr = 32'h100; branch = 1; zero = 1; branchaddr = 32'h200;
        tick("jump_over_branch");
        chk("jump_over_branch.explicit", longint'(pcvalue), 32'h100);
        go_to(32'h40);
        jr = 1; jraddr = 32'h300; jump = 1; jumpaddr = 32'h100;
        branch = 1; zero = 1; branchaddr = 32'h200;
        tick("jr_first");
        chk("jr_first.explicit", longint'(pcvalue), 32'h300);

        go_to(32'h40);
        stall = 1; jump = 1; jumpaddr = 32'h100; tick("stall1");
        stall = 1; jump = 1; jumpaddr = 32'h100; tick("stall2");
        chk("stall2.explicit", longint'(pcvalue), 32'h40);
        stall = 1; exc = 1; tick("stall_exc");
        chk("stall_exc.explicit", longint'(epc), 32'h40);

        go_to(32'h10);
        jump = 1; jumpaddr = 32'h102; tick("misalign");
        chk("misalign.explicit", longint'(misalign), 1);
        eret = 1; tick("eret");
        chk("eret.explicit", longint'(pcvalue), 32'h10);

        go_to(32'h20);
        halt = 1; tick("halt");
        for (int i = 0; i < 5; i++) begin
            jump = 1; jumpaddr = 32'h100; tick("halt_hold");
        end
        chk("halt_hold.explicit", longint'(pcvalue), 32'h20);
        irq = 1; tick("wake");
        chk("wake.explicit", longint'(epc), 32'h24);

        halt = 1; tick("halt2");
        async_reset("rst_in_halt");
        stall = 1; tick("post_rst_stall");
        tick("post_rst_seq");

        for (int i = 0; i < 600; i++) begin
            stall  = ($urandom_range(0, 3) == 0);
            branch = ($urandom_range(0, 3) == 0);
            zero   = $urandom_range(0, 1) != 0;
            jump   = ($urandom_range(0, 7) == 0);
            jr     = ($urandom_range(0, 9) == 0);
            exc    = ($urandom_range(0, 19) == 0);
            eret   = ($urandom_range(0, 14) == 0);
            halt   = ($urandom_range(0, 19) == 0);
            irq    = ($urandom_range(0, 4) == 0);
            branchaddr = $urandom & (($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            jumpaddr   = $urandom & (($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            jraddr     = $urandom & (($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            if (m_pc > 64'hFFFF_FF00 && $urandom_range(0, 1) == 0) jumpaddr = 32'hFFFF_FFF8;
            tick("rand");
        end

        go_to(32'hFFFF_FFFC);
        tick("wrap32");
        chk("wrap32.explicit", longint'(pcvalue), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 32, program-counter width in bits (>= 8).
REQ-002 Parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-003 Parameter EXC_VECTOR, default 'h80, PC value loaded on exception, misalignment or wake-up.
REQ-004 Parameter STEP, default 4, sequential increment.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 stall  in  1  hold the PC this cycle (pipeline/memory wait).
REQ-008 branch, zero  in  1 each  taken branch when both are 1.
REQ-009 branchaddr  in  WIDTH  branch target.
REQ-010 jump  in  1; jumpaddr  in  WIDTH  absolute jump target.
REQ-011 jr  in  1; jraddr  in  WIDTH  register-indirect jump target.
REQ-012 exc  in  1  synchronous exception request.
REQ-013 eret  in  1  return from exception.
REQ-014 halt  in  1  enter low-power halt.
REQ-015 irq  in  1  wake-up request, sampled only in HALT.
REQ-016 pcvalue  out  WIDTH  current PC (registered).
REQ-017 pcnext_seq  out  WIDTH  combinational pcvalue + STEP, modulo 2^WIDTH.
REQ-018 epc  out  WIDTH  saved exception PC (registered).
REQ-019 misalign  out  1  registered one-cycle pulse flagging a misaligned redirect.
REQ-020 halted  out  1  registered; 1 while in HALT.

Function
REQ-021 Two-state FSM, RUN and HALT; halted SHALL equal (state == HALT).
REQ-022 In RUN, the next PC SHALL be chosen by fixed priority: exc > eret > jr > jump > (branch & zero) > pcnext_seq.
REQ-023 Addition SHALL wrap modulo 2^WIDTH: pcvalue = 2^WIDTH-STEP -> pcnext_seq = 0, no flag.
REQ-024 On exc in RUN (stall ignored): pcvalue <= EXC_VECTOR, epc <= pcvalue.
REQ-025 If the selected jr/jump/branch target has bits [1:0] != 0: pcvalue <= EXC_VECTOR, epc <= pcvalue, misalign <= 1 for one cycle; stall is ignored.
REQ-026 On eret in RUN without exc and not stalled: pcvalue <= epc; epc unchanged.
REQ-027 When stall = 1 in RUN with no exc and no misaligned redirect, pcvalue, epc and state SHALL hold; all redirects that cycle are dropped.
REQ-028 halt = 1 in RUN, not stalled, no higher-priority redirect (exc/eret/jr/jump/taken branch): state <= HALT, pcvalue holds; redirects take precedence over halt.
REQ-029 In HALT: irq = 1 or exc = 1 -> state <= RUN, pcvalue <= EXC_VECTOR, epc <= pcnext_seq; all other inputs ignored, pcvalue holds.
REQ-030 misalign SHALL be 0 in every cycle except the one following a misaligned redirect.
REQ-031 Latency: every redirect appears on pcvalue exactly one clock after the inputs are sampled.

Reset
REQ-032 reset_n = 0 SHALL immediately, independent of clk, force pcvalue = RESET_VECTOR, epc = 0, misalign = 0, halted = 0, state = RUN.
REQ-033 Reset asserted mid-stall, mid-redirect or in HALT SHALL override all inputs; the first edge after release performs a normal RUN update.

Verification
REQ-034 Reset then 3 idle clocks -> pcvalue 0, 4, 8, 12; assert reset_n low between edges -> pcvalue 0 at once.
REQ-035 pcvalue = 0x40, jump=1 jumpaddr=0x100, branch=1 zero=1 branchaddr=0x200 -> next pcvalue 0x100; with jr=1 jraddr=0x300 also -> 0x300.
REQ-036 pcvalue = 0x40, stall=1 and jump=1 for 2 clocks -> pcvalue stays 0x40; stall=1 with exc=1 -> pcvalue 0x80, epc 0x40.
REQ-037 pcvalue = 0x10, jump=1 jumpaddr=0x102 -> pcvalue 0x80, epc 0x10, misalign 1 for exactly one cycle; then eret=1 -> pcvalue 0x10.
REQ-038 pcvalue = 0x20, halt=1 -> halted 1, pcvalue holds at 0x20 for 5 clocks with jump=1 applied; irq=1 -> pcvalue 0x80, epc 0x24, halted 0.
REQ-039 WIDTH=8, STEP=4, pcvalue = 0xFC idle -> pcvalue 0x00, misalign 0.
